vx_ibuf_sched: RTL and testbench
================================

VX_IBUF_SCHED -- requirements
Module: VX_ibuf_sched

Interface
REQ-001 SHALL expose parameter NUM_WARPS, default 4: number of requesting warps, power of two, at least 2.
REQ-002 SHALL expose parameter IBUF_SIZE, default 2: per-warp instruction-buffer depth, 1..15.
REQ-003 SHALL derive WID_W = log2(NUM_WARPS) and CRD_W = clog2(IBUF_SIZE+1).
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port warp_req  in  NUM_WARPS  warp i has an instruction ready to fetch.
REQ-007 SHALL have port warp_stall  in  NUM_WARPS  warp i is blocked by the scheduler.
REQ-008 SHALL have port grant_valid  out  1  a grant is offered downstream.
REQ-009 SHALL have port grant_wid  out  WID_W  warp id of the offered grant.
REQ-010 SHALL have port grant_ready  in  1  downstream fetch accepts the grant.
REQ-011 SHALL have port pop_valid  in  1  instruction buffer popped one entry; returns one credit.
REQ-012 SHALL have port pop_wid  in  WID_W  warp whose entry was popped.
REQ-013 SHALL have port credits  out  NUM_WARPS*CRD_W  per-warp free-entry counts, warp 0 in LSBs.
REQ-014 SHALL have port idle  out  1  all credits equal IBUF_SIZE and grant_valid = 0.
REQ-015 SHALL have port ovf_err  out  1  sticky flag: credit return on a full counter.

Function
REQ-016 SHALL keep one credit counter per warp, range 0..IBUF_SIZE.
REQ-017 SHALL treat warp i as eligible when warp_req[i]=1, warp_stall[i]=0 and its next-state credit > 0.
REQ-018 SHALL select among eligible warps round-robin, starting at (last granted wid + 1) mod NUM_WARPS and wrapping.
REQ-019 SHALL register grant_valid and grant_wid; eligibility at cycle t produces grant_valid=1 at t+1, with no combinational path from inputs to grant outputs.
REQ-020 SHALL hold grant_valid=1 and grant_wid stable while grant_ready=0, even if warp_req or warp_stall of that warp drops.
REQ-021 SHALL treat grant_valid & grant_ready as a handshake that decrements credit[grant_wid] by 1 and sets the round-robin pointer to grant_wid.
REQ-022 SHALL compute the next grant in the handshake cycle from next-state credits and the updated pointer, so that back-to-back grants are possible every cycle.
REQ-023 SHALL drive grant_valid=0 at the next edge when no warp is eligible, and grant_wid SHALL then hold its last value.
REQ-024 SHALL increment credit[pop_wid] by 1 on pop_valid=1.
REQ-025 SHALL apply a handshake and a pop to the same warp in the same cycle as a net-zero credit change.
REQ-026 SHALL, on a pop to a warp whose credit is already IBUF_SIZE, saturate the credit and set ovf_err=1 until reset.
REQ-027 SHALL never issue a grant for a warp whose credit is 0, by construction.
REQ-028 SHALL drive credits and idle directly from registered state.

Reset
REQ-029 SHALL apply the following while reset=0 at a clock edge: grant_valid=0, grant_wid=0, round-robin pointer = NUM_WARPS-1 (so warp 0 has first priority), every credit = IBUF_SIZE, ovf_err=0, idle=1.
REQ-030 SHALL, when reset is asserted mid-handshake, discard the pending grant and ignore that cycle's pop_valid.
REQ-031 SHALL allow the first grant no earlier than the second edge after reset deasserts.

Verification
REQ-032 Bench SHALL cover this scenario: reset release, warp_req=4'b1111, stall=0, grant_ready=1 -> grants wid 0,1,2,3,0,1,2,3 on consecutive cycles, then grant_valid=0 once all credits reach 0 (IBUF_SIZE=2, eight grants).
REQ-033 Bench SHALL cover this scenario: grant offered for wid 2, grant_ready=0 for 5 cycles while warp_req[2] drops -> grant_wid stays 2, credit[2] unchanged until the accepting cycle, then decrements to 1.
REQ-034 Bench SHALL cover this scenario: credit[1]=0 and warp_req[1]=1, then pop_valid with pop_wid=1 -> grant for wid 1 appears on the following edge (other warps idle).
REQ-035 Bench SHALL cover this scenario: handshake wid 3 and pop wid 3 in the same cycle with credit[3]=1 -> credit[3] stays 1.
REQ-036 Bench SHALL cover this scenario: pop_wid=0 with credit[0]=2 (full) -> credit[0] stays 2, ovf_err=1 and held until reset=0.
REQ-037 Bench SHALL cover this scenario: reset=0 asserted during a stalled grant -> next cycle grant_valid=0, credits=2 each, idle=1.

Source files
------------

// File: rtl/vx_ibuf_sched.sv
// vx_ibuf_sched: per-warp instruction-buffer credit tracking with a
// registered round-robin fetch grant. A handshake consumes a credit,
// a buffer pop returns one; the grant is recomputed from next-state
// credits so a new grant can follow every accepted one.
module vx_ibuf_sched #(
  parameter int NUM_WARPS = 4,
  parameter int IBUF_SIZE = 2,
  localparam int WID_W = $clog2(NUM_WARPS),
  localparam int CRD_W = $clog2(IBUF_SIZE + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WARPS-1:0]       warp_req,
  input  logic [NUM_WARPS-1:0]       warp_stall,
  output logic                       grant_valid,
  output logic [WID_W-1:0]           grant_wid,
  input  logic                       grant_ready,
  input  logic                       pop_valid,
  input  logic [WID_W-1:0]           pop_wid,
  output logic [NUM_WARPS*CRD_W-1:0] credits,
  output logic                       idle,
  output logic                       ovf_err
);

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(IBUF_SIZE);

  logic [CRD_W-1:0] r_credit [NUM_WARPS];
  logic [CRD_W-1:0] w_credit_next [NUM_WARPS];
  logic             r_grant_valid;
  logic [WID_W-1:0] r_grant_wid;
  logic [WID_W-1:0] r_rr_ptr;
  logic             r_started;
  logic             r_ovf_err;

  logic                 w_hs;
  logic [NUM_WARPS-1:0] w_dec;
  logic [NUM_WARPS-1:0] w_inc;
  logic [NUM_WARPS-1:0] w_full;
  logic [NUM_WARPS-1:0] w_ovf;
  logic [NUM_WARPS-1:0] w_elig;
  logic [WID_W-1:0]     w_base;
  logic [WID_W-1:0]     w_idx;
  logic [WID_W-1:0]     w_pick;
  logic                 w_found;

  assign w_hs   = r_grant_valid & grant_ready;
  // After a handshake the search restarts just past the warp that was accepted.
  assign w_base = w_hs ? r_grant_wid : r_rr_ptr;

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    assign w_dec[gi]  = w_hs & (r_grant_wid == WID_W'(gi));
    assign w_inc[gi]  = pop_valid & (pop_wid == WID_W'(gi));
    assign w_full[gi] = (r_credit[gi] == CRD_MAX);
    // A pop that meets a simultaneous handshake cancels out, so it never overflows.
    assign w_ovf[gi]  = w_inc[gi] & ~w_dec[gi] & w_full[gi];
    assign w_credit_next[gi] =
        (w_dec[gi] & ~w_inc[gi])               ? r_credit[gi] - CRD_W'(1) :
        (w_inc[gi] & ~w_dec[gi] & ~w_full[gi]) ? r_credit[gi] + CRD_W'(1) :
                                                 r_credit[gi];
    // r_started keeps the first grant off the first edge after reset release.
    assign w_elig[gi] = r_started & warp_req[gi] & ~warp_stall[gi] &
                        (w_credit_next[gi] != '0);
    assign credits[gi*CRD_W +: CRD_W] = r_credit[gi];
  end

  // Round-robin pick: first eligible warp after w_base, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      w_idx = w_base + WID_W'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Credit counters: reset to full, otherwise take the netted next value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!reset) begin
        r_credit[i] <= CRD_MAX;
      end else begin
        r_credit[i] <= w_credit_next[i];
      end
    end
  end

  // Grant register, round-robin pointer, start-up delay and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant_valid <= 1'b0;
      r_grant_wid   <= '0;
      r_rr_ptr      <= WID_W'(NUM_WARPS - 1);
      r_started     <= 1'b0;
      r_ovf_err     <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (w_ovf != '0) begin
        r_ovf_err <= 1'b1;
      end
      // An offered grant is frozen until accepted.
      if (!r_grant_valid || grant_ready) begin
        r_rr_ptr      <= w_base;
        r_grant_valid <= w_found;
        if (w_found) begin
          r_grant_wid <= w_pick;
        end
      end
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_wid   = r_grant_wid;
  assign ovf_err     = r_ovf_err;
  assign idle        = (&w_full) & ~r_grant_valid;

endmodule

// File: tb/tb_vx_ibuf_sched.sv
// tb_vx_ibuf_sched: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural credit/round-robin model.
module tb_vx_ibuf_sched;
  localparam int NW = 4;
  localparam int IB = 2;
  localparam int WW = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NW-1:0] warp_req = '0;
  logic [NW-1:0] warp_stall = '0;
  logic          grant_valid;
  logic [WW-1:0] grant_wid;
  logic          grant_ready = 1'b0;
  logic          pop_valid = 1'b0;
  logic [WW-1:0] pop_wid = '0;
  logic [NW*CW-1:0] credits;
  logic          idle;
  logic          ovf_err;

  vx_ibuf_sched #(.NUM_WARPS(NW), .IBUF_SIZE(IB)) dut (
    .clk(clk), .reset(reset), .warp_req(warp_req), .warp_stall(warp_stall),
    .grant_valid(grant_valid), .grant_wid(grant_wid), .grant_ready(grant_ready),
    .pop_valid(pop_valid), .pop_wid(pop_wid), .credits(credits),
    .idle(idle), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  int m_cred [NW];
  int m_ptr;
  int m_gw;
  bit m_gv;
  bit m_ovf;
  bit m_started;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_cred(input int i);
    return int'(credits[i*CW +: CW]);
  endfunction

  function automatic bit model_idle();
    bit r = !m_gv;
    for (int i = 0; i < NW; i++) if (m_cred[i] != IB) r = 1'b0;
    return r;
  endfunction

  // One clock edge of the reference behaviour, from the inputs seen at that edge.
  function automatic void model_step();
    int  nc [NW];
    bit  hs;
    int  base;
    int  w;
    bit  found;
    if (!reset) begin
      for (int i = 0; i < NW; i++) m_cred[i] = IB;
      m_ptr = NW - 1; m_gw = 0; m_gv = 0; m_ovf = 0; m_started = 0;
      return;
    end
    hs = m_gv && grant_ready;
    for (int i = 0; i < NW; i++) nc[i] = m_cred[i];
    if (hs) nc[m_gw] = nc[m_gw] - 1;
    if (pop_valid) begin
      if (nc[pop_wid] >= IB) m_ovf = 1;
      else nc[pop_wid] = nc[pop_wid] + 1;
    end
    if (!(m_gv && !grant_ready)) begin
      base  = hs ? m_gw : m_ptr;
      m_ptr = base;
      found = 0;
      for (int k = 1; k <= NW; k++) begin
        w = (base + k) % NW;
        if (!found && m_started && warp_req[w] && !warp_stall[w] && nc[w] > 0) begin
          found = 1;
          m_gw  = w;
        end
      end
      m_gv = found;
    end
    for (int i = 0; i < NW; i++) m_cred[i] = nc[i];
    m_started = 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  // Compare every DUT output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant_valid", grant_valid, m_gv);
      chk("grant_wid", grant_wid, m_gw);
      for (int i = 0; i < NW; i++) chk($sformatf("credit%0d", i), dut_cred(i), m_cred[i]);
      chk("idle", idle, model_idle());
      chk("ovf_err", ovf_err, m_ovf);
    end
  end

  initial begin
    int w;
    reset = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b1;
    // reset state
    chk("rst_gv", grant_valid, 0);
    chk("rst_wid", grant_wid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ovf", ovf_err, 0);
    for (int i = 0; i < NW; i++) chk("rst_cred", dut_cred(i), IB);

    // all warps requesting, always ready: 0,1,2,3,0,1,2,3 then dry
    reset = 1'b1; warp_req = 4'b1111; grant_ready = 1'b1;
    cyc();
    chk("first_edge_no_grant", grant_valid, 0);
    cyc();
    for (int k = 0; k < 8; k++) begin
      chk("seq_gv", grant_valid, 1);
      chk("seq_wid", grant_wid, k % 4);
      cyc();
    end
    chk("dry_gv", grant_valid, 0);
    chk("dry_idle", idle, 0);
    for (int i = 0; i < NW; i++) chk("dry_cred", dut_cred(i), 0);

    // pop returns credit to starved warp 1 -> grant on the next edge
    warp_req = 4'b0010; pop_valid = 1'b1; pop_wid = 2'd1;
    cyc();
    pop_valid = 1'b0; warp_req = 4'b0000;
    chk("pop_gv", grant_valid, 1);
    chk("pop_wid", grant_wid, 1);
    chk("pop_cred1", dut_cred(1), 1);
    cyc();
    chk("pop_cred1_used", dut_cred(1), 0);

    // grant for wid 2 held while not ready, req drops
    do_reset();
    warp_req = 4'b0100; grant_ready = 1'b0;
    cyc();
    cyc();
    chk("hold_gv", grant_valid, 1);
    chk("hold_wid", grant_wid, 2);
    warp_req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("hold_gv", grant_valid, 1);
      chk("hold_wid", grant_wid, 2);
      chk("hold_cred2", dut_cred(2), 2);
    end
    grant_ready = 1'b1;
    cyc();
    chk("accept_cred2", dut_cred(2), 1);
    chk("accept_gv", grant_valid, 0);

    // handshake and pop on wid 3 in the same cycle
    do_reset();
    warp_req = 4'b1000; grant_ready = 1'b0;
    cyc();
    cyc();
    grant_ready = 1'b1;
    cyc();
    chk("net_pre_cred3", dut_cred(3), 1);
    chk("net_pre_wid", grant_wid, 3);
    pop_valid = 1'b1; pop_wid = 2'd3;
    cyc();
    chk("net_cred3", dut_cred(3), 1);
    chk("net_ovf", ovf_err, 0);
    pop_valid = 1'b0; warp_req = 4'b0000;
    cyc();

    // pop on a full counter sets the sticky overflow
    do_reset();
    pop_valid = 1'b1; pop_wid = 2'd0;
    cyc();
    pop_valid = 1'b0;
    chk("ovf_cred0", dut_cred(0), 2);
    chk("ovf_set", ovf_err, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ovf_sticky", ovf_err, 1);
    end

    // reset during a stalled grant, with a pop that must be ignored
    warp_req = 4'b0001; grant_ready = 1'b0;
    cyc();
    chk("stall_gv", grant_valid, 1);
    reset = 1'b0; pop_valid = 1'b1; pop_wid = 2'd1;
    cyc();
    chk("rst_mid_gv", grant_valid, 0);
    chk("rst_mid_idle", idle, 1);
    chk("rst_mid_ovf", ovf_err, 0);
    for (int i = 0; i < NW; i++) chk("rst_mid_cred", dut_cred(i), IB);
    reset = 1'b1; pop_valid = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) != 0);
      warp_req    = NW'($urandom);
      warp_stall  = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '0;
      grant_ready = ($urandom_range(0, 2) != 0);
      w           = $urandom_range(0, NW - 1);
      pop_wid     = WW'(w);
      pop_valid   = (m_cred[w] < IB) ? ($urandom_range(0, 1) == 1)
                                     : ($urandom_range(0, 49) == 0);
      cyc();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
